// File: rtl/sequential_multiplier_pkg.sv
// Shared types and defaults for the shift-and-add sequential multiplier.
package sequential_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sequential_multiplier_if.sv
// Operand/result bundle between a requester (master) and the multiplier (slave).
interface sequential_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] product;
  logic               done;

  modport master (
    output start, A, B,
    input  product, done
  );

  modport slave (
    input  start, A, B,
    output product, done
  );
endinterface

// File: rtl/seq_mult_datapath.sv
// Multiplicand/multiplier/accumulator registers and the single shifted adder.
module seq_mult_datapath
  import sequential_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [CNT_W-1:0]   i_count,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc_next
);

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_addend;

  always_comb begin
    w_addend   = {{WIDTH{1'b0}}, r_mcand} << i_count;
    o_acc_next = r_mplier[0] ? (r_acc + w_addend) : r_acc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (i_step) begin
      r_acc    <= o_acc_next;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/sequential_multiplier.sv
// Unsigned shift-and-add multiplier: one multiplier bit per clock, registered result.
module sequential_multiplier
  import sequential_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  sequential_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_product;
  logic               r_done;

  logic               w_load;
  logic               w_step;
  logic [2*WIDTH-1:0] w_acc_next;

  // DONE accepts a new start exactly like IDLE, giving WIDTH+1 cycle throughput.
  always_comb begin
    w_load = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
    w_step = (r_state == BUSY);
  end

  seq_mult_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_count    (r_count),
    .i_a        (bus.A),
    .i_b        (bus.B),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_count <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_count <= r_count + 1'b1;
          // Last step: capture the sum including this cycle's partial product.
          if (r_count == LAST_STEP) begin
            r_product <= w_acc_next;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_count <= '0;
            r_state <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.product = r_product;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed bench for sequential_multiplier with hand-computed products.
module tb_sequential_multiplier;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  sequential_multiplier_if #(.WIDTH(8)) bus();

  sequential_multiplier #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and follow it to completion; optionally inject a
  // start pulse with different operands while the first is still busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit inject);
    logic [15:0] prev;
    prev      = bus.product;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("busy_done", 32'(bus.done), 32'd0);
      chk("busy_product_hold", 32'(bus.product), 32'(prev));
      if (inject && k == 3) begin
        bus.start = 1'b1;
        bus.A     = 8'd3;
        bus.B     = 8'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    tick();
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("product", 32'(bus.product), 32'(exp));
    tick();
    chk("done_clear", 32'(bus.done), 32'd0);
    chk("product_after_done", 32'(bus.product), 32'(exp));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.A     = 8'd0;
    bus.B     = 8'd0;

    tick();
    tick();
    chk("reset_product", 32'(bus.product), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_product", 32'(bus.product), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);

    run_op(8'd15, 8'd10, 16'd150, 1'b0);
    run_op(8'd255, 8'd255, 16'd65025, 1'b0);
    run_op(8'd0, 8'd200, 16'd0, 1'b0);
    run_op(8'd15, 8'd10, 16'd150, 1'b1);

    // Abort an operation with reset partway through.
    bus.A     = 8'd15;
    bus.B     = 8'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("abort_product", 32'(bus.product), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("abort_no_done", 32'(bus.done), 32'd0);
      chk("abort_product_hold", 32'(bus.product), 32'd0);
    end
    run_op(8'd7, 8'd6, 16'd42, 1'b0);

    // Start held high: a result every 9 cycles.
    bus.A     = 8'd2;
    bus.B     = 8'd5;
    bus.start = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 9; k++) begin
        tick();
        chk("b2b_done", 32'(bus.done), (k == 8) ? 32'd1 : 32'd0);
        if (k == 8) chk("b2b_product", 32'(bus.product), 32'd10);
      end
    end
    bus.start = 1'b0;
    repeat (10) tick();
    chk("b2b_final_product", 32'(bus.product), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
